// File: rtl/imu_burst_reader.sv
// rtl/imu_burst_reader.sv - periodic SPI burst reader publishing one atomic IMU sample per tick
// Optional per-byte watchdog with sticky timeout_err output: define IMU_TIMEOUT_EN.
`timescale 1ns/1ps
module imu_burst_reader #(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter logic [7:0]  START_REG  = 8'h3B,
    parameter int unsigned NUM_WORDS  = 7,
    parameter int unsigned CS_GUARD   = 4,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                    clk_system,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    spi_ready,
    output logic                    spi_start,
    output logic [7:0]              spi_tx_data,
    input  logic                    spi_done,
    input  logic [7:0]              spi_rx_data,
    output logic                    spi_cs_n,
    output logic [16*NUM_WORDS-1:0] sample_bus,
    output logic                    sample_valid,
    output logic                    overrun,
`ifdef IMU_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    output logic                    busy
);
    localparam int unsigned NB = 2 * NUM_WORDS;
    localparam int unsigned IW = $clog2(NB);
    localparam int unsigned CW = $clog2(SAMPLE_DIV);
    localparam int unsigned GW = $clog2(CS_GUARD + 1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SEND_ADDR, WAIT_ADDR, SEND_DUMMY, WAIT_BYTE, CS_HOLD, PUBLISH
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [GW-1:0]           guard_q, guard_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NB-1:0][7:0]      shadow_q, shadow_d;
    logic                    cs_n_q, cs_n_d;
    logic                    start_q, start_d;
    logic [7:0]              tx_q, tx_d;
    logic [16*NUM_WORDS-1:0] bus_q, bus_d;
    logic [16*NUM_WORDS-1:0] packed_shadow;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    busy_q, busy_d;
    logic                    tick;
`ifdef IMU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]           wdog_q, wdog_d;
    logic                    terr_q, terr_d;
`endif

    // Shadow byte 2w is the high byte of word w (IMU registers are big-endian).
    always_comb begin
        packed_shadow = '0;
        for (int w = 0; w < int'(NUM_WORDS); w++) begin
            packed_shadow[16*w +: 16] = {shadow_q[2*w], shadow_q[2*w+1]};
        end
    end

    always_comb begin
        tick      = (cnt_q == CW'(SAMPLE_DIV - 1));
        cnt_d     = tick ? '0 : cnt_q + CW'(1);
        state_d   = state_q;
        guard_d   = guard_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        cs_n_d    = cs_n_q;
        start_d   = 1'b0;
        tx_d      = tx_q;
        bus_d     = bus_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        overrun_d = overrun_q | (tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    state_d = CS_SETUP;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    guard_d = GW'(1);
                end
            end
            CS_SETUP: begin
                if (guard_q >= GW'(CS_GUARD - 1)) state_d = SEND_ADDR;
                else                               guard_d = guard_q + GW'(1);
            end
            SEND_ADDR: begin
                if (spi_ready) begin
                    start_d = 1'b1;
                    tx_d    = START_REG | 8'h80;
                    state_d = WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                if (spi_done) begin
                    idx_d   = '0;
                    state_d = SEND_DUMMY;
                end
            end
            SEND_DUMMY: begin
                if (spi_ready) begin
                    start_d = 1'b1;
                    tx_d    = 8'h00;
                    state_d = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (spi_done) begin
                    for (int i = 0; i < int'(NB); i++) begin
                        if (idx_q == IW'(i)) shadow_d[i] = spi_rx_data;
                    end
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(NB - 1)) begin
                        state_d = CS_HOLD;
                        guard_d = GW'(1);
                    end else begin
                        state_d = SEND_DUMMY;
                    end
                end
            end
            CS_HOLD: begin
                if (guard_q >= GW'(CS_GUARD - 1)) begin
                    cs_n_d  = 1'b1;
                    state_d = PUBLISH;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            PUBLISH: begin
                bus_d   = packed_shadow;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef IMU_TIMEOUT_EN
        wdog_d = wdog_q;
        terr_d = terr_q;
        if (start_d) begin
            wdog_d = '0;
        end else if ((state_q == WAIT_ADDR || state_q == WAIT_BYTE) && !spi_done) begin
            // Abort drops the partial shadow; the next burst overwrites every byte anyway.
            if (wdog_q >= TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                terr_d  = 1'b1;
                wdog_d  = '0;
            end else begin
                wdog_d = wdog_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk_system or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            guard_q   <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            cs_n_q    <= 1'b1;
            start_q   <= 1'b0;
            tx_q      <= '0;
            bus_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef IMU_TIMEOUT_EN
            wdog_q    <= '0;
            terr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            cs_n_q    <= cs_n_d;
            start_q   <= start_d;
            tx_q      <= tx_d;
            bus_q     <= bus_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
`ifdef IMU_TIMEOUT_EN
            wdog_q    <= wdog_d;
            terr_q    <= terr_d;
`endif
        end
    end

    assign spi_cs_n     = cs_n_q;
    assign spi_start    = start_q;
    assign spi_tx_data  = tx_q;
    assign sample_bus   = bus_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;
`ifdef IMU_TIMEOUT_EN
    assign timeout_err  = terr_q;
`endif

endmodule
